// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32 divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } div_state_e;

    localparam logic [31:0] DIV_INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_abs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // rem < divisor_abs always holds, so the borrow bit alone says whether it fits
    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, divisor_abs};
    assign rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with RISC-V corner-case results.
module seq_divider32
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] quo_fin, rem_fin;
    logic [WIDTH-1:0] step_rem, step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_q),
        .quo         (quo_q),
        .divisor_abs (dsr_q),
        .rem_next    (step_rem),
        .quo_next    (step_quo)
    );

    // busy_q stays high through the valid cycle, so it alone gates acceptance
    assign accept    = start && !busy_q;
    assign signed_op = (op_q == DIV) || (op_q == REM);
    assign a_neg     = signed_op && a_q[WIDTH-1];
    assign b_neg     = signed_op && b_q[WIDTH-1];
    assign a_abs     = a_neg ? -a_q : a_q;
    assign b_abs     = b_neg ? -b_q : b_q;
    assign quo_fin   = neg_quo_q ? -quo_q : quo_q;
    assign rem_fin   = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        dsr_d     = dsr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        busy_d    = accept || (state_q != IDLE);
        valid_d   = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = div_op_e'(op);
                    a_d     = dividend;
                    b_d     = divisor;
                    state_d = PREP;
                end
            end
            PREP: begin
                quo_d     = a_abs;
                rem_d     = '0;
                dsr_d     = b_abs;
                cnt_d     = CNT_W'(WIDTH - 1);
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                state_d   = CALC;
                // Corner cases load final values directly and skip sign fix-up
                if (b_q == '0) begin
                    quo_d     = '1;
                    rem_d     = a_q;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = DONE;
                end else if (signed_op && a_q == DIV_INT_MIN && b_q == '1) begin
                    quo_d     = DIV_INT_MIN;
                    rem_d     = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = DONE;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                result_d = (op_q == DIV || op_q == DIVU) ? quo_fin : rem_fin;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            a_q       <= '0;
            b_q       <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dsr_q     <= dsr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Randomized and directed checks of seq_divider32 against an arithmetic reference.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] prev_res = 32'h0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    always #5 clk = ~clk;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .valid    (valid),
        .result   (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == MIN && b == 32'hFFFF_FFFF);
    endfunction

    // op[0]=1 unsigned, op[1]=1 remainder
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0)                                    return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == MIN && b == 32'hFFFF_FFFF)       return o[1] ? 32'h0 : MIN;
        if (o[0])                                          return o[1] ? a % b : a / b;
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit noisy);
        logic [31:0] exp;
        logic [31:0] res;
        int          exp_lat;
        int          lat;
        bit          busy_ok;
        bit          held_ok;
        exp     = ref_model(o, a, b);
        exp_lat = is_special(o, a, b) ? 2 : 34;
        lat     = 0;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        res     = 32'hDEAD_BEEF;
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        if (noisy) begin
            op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        end
        if (!busy) busy_ok = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                lat = k;
                res = result;
                break;
            end
            if (result !== prev_res) held_ok = 1'b0;
            start = noisy && (k == 4);
            if (noisy && k == 4) begin
                op = 2'b01; dividend = 32'd1; divisor = 32'd1;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, res, exp);
        chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_hold"}, {31'b0, held_ok}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk({tag, "_fall"}, {30'b0, valid, busy}, 32'd0);
        prev_res = res;
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int          nv;
        rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;

        do_op(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b1);
        do_op(2'b11, 32'd100, 32'd7, "remu_100_7", 1'b0);
        do_op(2'b00, -32'sd7, 32'd2, "div_m7_2", 1'b1);
        do_op(2'b10, -32'sd7, 32'd2, "rem_m7_2", 1'b0);
        do_op(2'b10, 32'd7, -32'sd2, "rem_7_m2", 1'b0);
        do_op(2'b01, 32'h1234, 32'd0, "divu_by0", 1'b0);
        do_op(2'b10, 32'h1234, 32'd0, "rem_by0", 1'b0);
        do_op(2'b00, -32'sd5, 32'd0, "div_m5_by0", 1'b1);
        do_op(2'b00, MIN, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        do_op(2'b10, MIN, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, "b2b_first", 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_second", 1'b0);

        // Reset in the middle of an operation must abort it silently
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        nv = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (valid) nv++;
        end
        chk("midrst_novalid", 32'(nv), 32'd0);
        prev_res = 32'h0;

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(o, a, b, $sformatf("rnd%0d", i), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_divider32.md
Name: seq_divider32

Overview:
- Multi-cycle restoring divider for the RV32 execute stage; implements DIV, DIVU, REM and REMU.
- It is the inverse counterpart of the core's 32-bit ripple adder.
- Uses one trial subtraction per cycle (shift-subtract) instead of combinational addition.
- Sits beside the ALU; the pipeline stalls on busy and captures result on valid.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is verified)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
dividend  input  WIDTH  rs1 value; sampled with start
divisor  input  WIDTH  rs2 value; sampled with start
busy  output  1  high from the cycle after acceptance through the DONE cycle
valid  output  1  one-cycle pulse; result is valid in that cycle
result  output  WIDTH  quotient or remainder; held until the next accepted start

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-high (rst).
  - While rst=1 at a clock edge: state=IDLE, busy=0, valid=0, result=0, internal regs=0.
  - Reset mid-operation aborts the operation; no valid is produced for it.
- States:
  - IDLE: busy=0, valid=0.
    - start=1 -> latch op/operands, go to PREP.
    - start=0 -> stay in IDLE.
  - PREP (1 cycle):
    - Signed ops: take |dividend| and |divisor|; record sign_q = sign(a) XOR sign(b) and sign_r = sign(a).
    - Unsigned ops: clear both sign flags.
    - Load quotient reg = |dividend|, remainder reg = 0, count = WIDTH-1.
    - Special cases go to DONE; otherwise go to CALC.
  - CALC (WIDTH cycles), each cycle:
    - Form {rem, quo} << 1.
    - Trial = rem_shifted - divisor_abs, computed at WIDTH+1 bits.
    - If trial is non-negative: rem = trial and shift in quotient bit 1.
    - Else: keep rem_shifted and shift in 0.
    - At count=0 go to DONE; otherwise decrement count.
  - DONE (1 cycle):
    - Apply signs: negate quo if sign_q, negate rem if sign_r.
    - Register result: quotient for DIV/DIVU, remainder for REM/REMU.
    - valid=1, busy=1 in this cycle; next state IDLE.
- Latency:
  - Normal operation: start sampled at edge 0, valid high after edge WIDTH+2 (34 cycles for WIDTH=32).
  - Special cases: valid after edge 2.
- Special cases (decided in PREP, RISC-V semantics):
  - divisor=0: quotient = all ones (0xFFFFFFFF) for DIV and DIVU; remainder = dividend.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Handshake:
  - start while busy=1 is ignored; it is neither queued nor latched.
  - start in the same cycle that valid falls (back in IDLE) is accepted normally.
  - Back-to-back issue: the earliest next acceptance is the cycle after DONE.
- Input stability:
  - Operands and op are only sampled at acceptance.
  - Later changes to the inputs have no effect on an operation in progress.
- Width rules:
  - Trial subtraction is WIDTH+1 bits wide; its borrow (MSB) selects the quotient bit.
  - Negation is two's complement at WIDTH bits; -0x80000000 wraps to itself.

Decomposition:
- Package div_pkg holds:
  - enum div_op_e (DIV, DIVU, REM, REMU, 2-bit).
  - enum div_state_e (IDLE, PREP, CALC, DONE).
  - constant DIV_INT_MIN = 32'h80000000.
- Combinational sub-module div_step:
  - Inputs: rem, quo, divisor_abs.
  - Outputs: next rem and next quo for one shift-subtract iteration.
  - Keeps the FSM and datapath registers in seq_divider32 separate from the arithmetic.

Test Plan:
- Reset mid-op: start DIVU 100/7, assert rst at cycle 10 -> busy=0, valid=0, result=0 next cycle; no valid pulse is ever produced for that operation.
- Basic unsigned, DIVU and REMU on 100/7: DIVU -> result=14 with valid at cycle 34; REMU -> result=2. Check that busy stays high for cycles 1..34 and that start at cycle 5 is ignored.
- Signed quotient and remainder:
  - DIV -7/2 -> 0xFFFFFFFD (-3).
  - REM -7/2 -> 0xFFFFFFFF (-1).
  - REM 7/-2 -> 1.
- Divide by zero:
  - DIVU 0x1234/0 -> 0xFFFFFFFF at cycle 2.
  - REM 0x1234/0 -> 0x1234.
  - DIV -5/0 -> 0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; both with valid at cycle 2.
- Back-to-back and hold:
  - Issue DIVU 0xFFFFFFFF/1, then DIVU 0xFFFFFFFF/0xFFFFFFFF the cycle after DONE.
  - Expect results 0xFFFFFFFF then 1.
  - The first result is held unchanged until the second valid.
